// File: rtl/gp_register_file.sv
// rtl/gp_register_file.sv - two-read/one-write register file with per-register scoreboard lock bits
// Reads are registered; same-edge write data and busy changes are bypassed into the read result.
module gp_register_file #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_sel,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      lock_en,
    input  logic [ADDR_W-1:0]         lock_sel,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         ra_sel,
    input  logic [ADDR_W-1:0]         rb_sel,
    output logic [WIDTH-1:0]          ra_out,
    output logic [WIDTH-1:0]          rb_out,
    output logic                      ra_busy,
    output logic                      rb_busy,
    output logic [(1<<ADDR_W)-1:0]    busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regFile [DEPTH];
    logic [DEPTH-1:0] busyBits;
    logic [DEPTH-1:0] busyNext;
    logic             wrOk;
    logic             lockOk;
    logic [WIDTH-1:0] raData;
    logic [WIDTH-1:0] rbData;
    logic             raBusyNext;
    logic             rbBusyNext;

    function automatic logic isHardZero(input logic [ADDR_W-1:0] sel);
        return (ZERO_REG != 0) && (sel == '0);
    endfunction

    // Lock is applied after the write clear so a same-edge lock wins.
    always_comb begin
        wrOk   = wr_en && !isHardZero(wr_sel);
        lockOk = lock_en && !isHardZero(lock_sel);
        busyNext = busyBits;
        if (wrOk) begin
            busyNext[wr_sel] = 1'b0;
        end
        if (lockOk) begin
            busyNext[lock_sel] = 1'b1;
        end
    end

    always_comb begin
        raData     = regFile[ra_sel];
        rbData     = regFile[rb_sel];
        raBusyNext = busyNext[ra_sel];
        rbBusyNext = busyNext[rb_sel];
        if (wrOk && (ra_sel == wr_sel)) begin
            raData = wr_data;
        end
        if (wrOk && (rb_sel == wr_sel)) begin
            rbData = wr_data;
        end
        if (isHardZero(ra_sel)) begin
            raData     = '0;
            raBusyNext = 1'b0;
        end
        if (isHardZero(rb_sel)) begin
            rbData     = '0;
            rbBusyNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile[i] <= '0;
            end
            busyBits <= '0;
            ra_out   <= '0;
            rb_out   <= '0;
            ra_busy  <= 1'b0;
            rb_busy  <= 1'b0;
        end else begin
            if (wrOk) begin
                regFile[wr_sel] <= wr_data;
            end
            busyBits <= busyNext;
            if (rd_en) begin
                ra_out  <= raData;
                rb_out  <= rbData;
                ra_busy <= raBusyNext;
                rb_busy <= rbBusyNext;
            end
        end
    end

    assign busy_vec = busyBits;

endmodule

// File: tb/tb_gp_register_file.sv
// tb/tb_gp_register_file.sv - self-checking bench for gp_register_file (default and ZERO_REG=1 instances)
module tb_gp_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [3:0]  wrSel;
    logic [15:0] wrData;
    logic        lockEn;
    logic [3:0]  lockSel;
    logic        rdEn;
    logic [3:0]  raSel;
    logic [3:0]  rbSel;

    logic [15:0] raOut0, rbOut0, busyVec0;
    logic        raBusy0, rbBusy0;
    logic [15:0] raOut1, rbOut1, busyVec1;
    logic        raBusy1, rbBusy1;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    gp_register_file #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_sel(wrSel), .wr_data(wrData),
        .lock_en(lockEn), .lock_sel(lockSel), .rd_en(rdEn), .ra_sel(raSel), .rb_sel(rbSel),
        .ra_out(raOut0), .rb_out(rbOut0), .ra_busy(raBusy0), .rb_busy(rbBusy0), .busy_vec(busyVec0)
    );

    gp_register_file #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_sel(wrSel), .wr_data(wrData),
        .lock_en(lockEn), .lock_sel(lockSel), .rd_en(rdEn), .ra_sel(raSel), .rb_sel(rbSel),
        .ra_out(raOut1), .rb_out(rbOut1), .ra_busy(raBusy1), .rb_busy(rbBusy1), .busy_vec(busyVec1)
    );

    typedef struct {
        string       name;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        raB;
        logic        rbB;
        logic [15:0] bv;
    } expT;

    typedef struct {
        logic        we;
        logic [3:0]  ws;
        logic [15:0] wd;
        logic        le;
        logic [3:0]  ls;
        logic        re;
        logic [3:0]  as;
        logic [3:0]  bs;
        expT         e;
    } vecT;

    expT sbq[$];
    vecT tbl[13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
    endtask

    task automatic checkDut1(input expT e);
        check({e.name, "/z.ra_out"},   raOut1, e.ra);
        check({e.name, "/z.rb_out"},   rbOut1, e.rb);
        check({e.name, "/z.ra_busy"},  {15'd0, raBusy1}, {15'd0, e.raB});
        check({e.name, "/z.rb_busy"},  {15'd0, rbBusy1}, {15'd0, e.rbB});
        check({e.name, "/z.busy_vec"}, busyVec1, e.bv);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic we, input logic [3:0] ws, input logic [15:0] wd,
                        input logic le, input logic [3:0] ls,
                        input logic re, input logic [3:0] as, input logic [3:0] bs,
                        input expT e);
        expT got;
        wrEn = we; wrSel = ws; wrData = wd;
        lockEn = le; lockSel = ls;
        rdEn = re; raSel = as; rbSel = bs;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        check({got.name, ".ra_out"},   raOut0, got.ra);
        check({got.name, ".rb_out"},   rbOut0, got.rb);
        check({got.name, ".ra_busy"},  {15'd0, raBusy0}, {15'd0, got.raB});
        check({got.name, ".rb_busy"},  {15'd0, rbBusy0}, {15'd0, got.rbB});
        check({got.name, ".busy_vec"}, busyVec0, got.bv);
    endtask

    logic [15:0] mReg [16];
    logic [15:0] mBusy;
    logic [15:0] mRa, mRb;
    logic        mRaB, mRbB;

    initial begin
        expT e;
        rst = 1'b0;
        wrEn = 1'b0; wrSel = 4'd0; wrData = 16'd0;
        lockEn = 1'b0; lockSel = 4'd0;
        rdEn = 1'b0; raSel = 4'd0; rbSel = 4'd0;
        #3;
        e = '{"reset", 16'h0, 16'h0, 1'b0, 1'b0, 16'h0};
        check("reset.ra_out", raOut0, e.ra);
        check("reset.busy_vec", busyVec0, e.bv);
        checkDut1(e);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        //             we    ws     wd        le    ls     re    as     bs        name          ra        rb        raB   rbB   bv
        tbl[0]  = '{1'b1, 4'd3,  16'h1234, 1'b0, 4'd0, 1'b0, 4'd0,  4'd0,  '{"wr_r3",     16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000}};
        tbl[1]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 4'd3,  4'd0,  '{"rd_r3_r0",  16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000}};
        tbl[2]  = '{1'b1, 4'd5,  16'hBEEF, 1'b0, 4'd0, 1'b1, 4'd5,  4'd5,  '{"bypass_r5",  16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 16'h0000}};
        tbl[3]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd7, 1'b0, 4'd0,  4'd0,  '{"lock_r7",    16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 16'h0080}};
        tbl[4]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 4'd7,  4'd5,  '{"rd_locked",  16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'h0080}};
        tbl[5]  = '{1'b1, 4'd7,  16'h0001, 1'b0, 4'd0, 1'b0, 4'd0,  4'd0,  '{"wr_r7",      16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'h0000}};
        tbl[6]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 4'd7,  4'd3,  '{"rd_r7_r3",   16'h0001, 16'h1234, 1'b0, 1'b0, 16'h0000}};
        tbl[7]  = '{1'b1, 4'd2,  16'h00AA, 1'b1, 4'd2, 1'b1, 4'd2,  4'd7,  '{"lock_wins",  16'h00AA, 16'h0001, 1'b1, 1'b0, 16'h0004}};
        tbl[8]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd2, 1'b1, 4'd2,  4'd2,  '{"relock_r2",  16'h00AA, 16'h00AA, 1'b1, 1'b1, 16'h0004}};
        tbl[9]  = '{1'b1, 4'd2,  16'h0BB0, 1'b1, 4'd6, 1'b1, 4'd2,  4'd6,  '{"busy_byp",   16'h0BB0, 16'h0000, 1'b0, 1'b1, 16'h0040}};
        tbl[10] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b0, 4'd0,  4'd0,  '{"hold",       16'h0BB0, 16'h0000, 1'b0, 1'b1, 16'h0040}};
        tbl[11] = '{1'b1, 4'd15, 16'hFFFF, 1'b0, 4'd0, 1'b1, 4'd15, 4'd0,  '{"wr_r15",     16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0040}};
        tbl[12] = '{1'b1, 4'd6,  16'h6666, 1'b1, 4'd1, 1'b1, 4'd6,  4'd1,  '{"wr6_lock1",  16'h6666, 16'h0000, 1'b0, 1'b1, 16'h0002}};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].we, tbl[i].ws, tbl[i].wd, tbl[i].le, tbl[i].ls,
                 tbl[i].re, tbl[i].as, tbl[i].bs, tbl[i].e);
        end

        // Reset mid-operation with r1/r4 locked and r4 written.
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 1'b0, 4'd0, 4'd0, '{"lock_r4", 16'h6666, 16'h0000, 1'b0, 1'b1, 16'h0012});
        step(1'b1, 4'd4, 16'h5555, 1'b0, 4'd0, 1'b1, 4'd4, 4'd1, '{"wr_r4", 16'h5555, 16'h0000, 1'b0, 1'b1, 16'h0002});
        #2;
        rst = 1'b0;
        #1;
        e = '{"async_rst", 16'h0, 16'h0, 1'b0, 1'b0, 16'h0};
        check("async_rst.ra_out", raOut0, e.ra);
        check("async_rst.rb_busy", {15'd0, rbBusy0}, {15'd0, e.rbB});
        check("async_rst.busy_vec", busyVec0, e.bv);
        checkDut1(e);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd1, '{"post_rst_rd", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});

        // ZERO_REG behaviour, with the default instance as contrast.
        step(1'b1, 4'd1, 16'h1111, 1'b0, 4'd0, 1'b1, 4'd1, 4'd1, '{"wr_r1", 16'h1111, 16'h1111, 1'b0, 1'b0, 16'h0000});
        checkDut1('{"wr_r1", 16'h1111, 16'h1111, 1'b0, 1'b0, 16'h0000});
        step(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0, 4'd1, '{"wr_lock_r0", 16'hFFFF, 16'h1111, 1'b1, 1'b0, 16'h0001});
        checkDut1('{"wr_lock_r0", 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h0000});
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd0, 4'd0, '{"rd_r0", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'h0001});
        checkDut1('{"rd_r0", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000});

        // Random traffic against a behavioural model of the default instance.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) mReg[i] = 16'h0;
        mBusy = 16'h0; mRa = 16'h0; mRb = 16'h0; mRaB = 1'b0; mRbB = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic        we, le, re;
            logic [3:0]  ws, ls, as, bs;
            logic [15:0] wd;
            we = 1'($urandom_range(1)); le = 1'($urandom_range(3) == 0); re = 1'($urandom_range(1));
            ws = 4'($urandom_range(15)); ls = 4'($urandom_range(15));
            as = 4'($urandom_range(15)); bs = 4'($urandom_range(15));
            wd = 16'($urandom);
            if (we) begin
                mReg[ws] = wd;
                mBusy[ws] = 1'b0;
            end
            if (le) mBusy[ls] = 1'b1;
            if (re) begin
                mRa = mReg[as]; mRb = mReg[bs];
                mRaB = mBusy[as]; mRbB = mBusy[bs];
            end
            step(we, ws, wd, le, ls, re, as, bs, '{"rand", mRa, mRb, mRaB, mRbB, mBusy});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gp_register_file.md
GP_REGISTER_FILE -- requirements
Module: gp_register_file

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits of every register and data port.
REQ-002 Parameter ADDR_W, default 4: select width; the block holds DEPTH = 2^ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0: when 1, register 0 always reads as zero, and writes and locks to it are ignored.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 wr_en  in  1  write strobe.
REQ-007 wr_sel  in  ADDR_W  write register index.
REQ-008 wr_data  in  WIDTH  write data.
REQ-009 lock_en  in  1  scoreboard lock strobe; marks a register as awaiting a pending write.
REQ-010 lock_sel  in  ADDR_W  register index to lock.
REQ-011 rd_en  in  1  read strobe for both read ports.
REQ-012 ra_sel, rb_sel  in  ADDR_W each  read port A/B register index.
REQ-013 ra_out, rb_out  out  WIDTH each  registered read data, port A/B.
REQ-014 ra_busy, rb_busy  out  1 each  registered: the register read on port A/B was locked at read time.
REQ-015 busy_vec  out  DEPTH  current scoreboard bits, bit i = register i locked.

Function
REQ-016 The block SHALL hold DEPTH registers of WIDTH bits and one scoreboard bit per register.
REQ-017 On a clk edge with wr_en=1, register[wr_sel] SHALL take wr_data and busy[wr_sel] SHALL clear.
REQ-018 On a clk edge with lock_en=1, busy[lock_sel] SHALL set.
REQ-019 When lock_en=1 and wr_en=1 target the same index on one edge, the data SHALL be written and busy SHALL end set (lock wins).
REQ-020 A write to an unlocked register SHALL be accepted normally; a lock on an already-locked register SHALL leave it set.
REQ-021 Read latency SHALL be one cycle: on an edge with rd_en=1, ra_out/rb_out SHALL load register[ra_sel]/register[rb_sel], and ra_busy/rb_busy SHALL load busy[ra_sel]/busy[rb_sel].
REQ-022 With rd_en=0, ra_out, rb_out, ra_busy and rb_busy SHALL hold their values.
REQ-023 Write bypass: when rd_en=1, wr_en=1 and ra_sel==wr_sel on one edge, ra_out SHALL load wr_data; port B SHALL behave the same way.
REQ-024 Busy bypass: the same-edge write clear (REQ-017) and lock set (REQ-018) SHALL be reflected in ra_busy/rb_busy, following the precedence of REQ-019.
REQ-025 Ports A and B SHALL be independent; ra_sel==rb_sel SHALL return identical data on both.
REQ-026 With ZERO_REG=1: reads of index 0 SHALL return 0 with busy 0, busy_vec[0] SHALL stay 0, and writes/locks to index 0 SHALL have no effect, including bypass.
REQ-027 busy_vec SHALL be a direct view of the scoreboard bits with no added latency.
REQ-028 No combinational path SHALL exist from any input to ra_out, rb_out, ra_busy or rb_busy.

Reset
REQ-029 While rst=0, all registers, scoreboard bits, ra_out, rb_out, ra_busy, rb_busy and busy_vec SHALL be 0, asynchronously.
REQ-030 A write, lock or read in the same cycle rst deasserts SHALL take effect on the first rising edge after rst=1.
REQ-031 Reset asserted mid-sequence SHALL discard all pending locks and stored data, with no partial update.

Verification
REQ-032 Write/read, defaults: write r3=0x1234, then rd_en with ra_sel=3, rb_sel=0 -> next cycle ra_out=0x1234, rb_out=0x0000, both busy=0.
REQ-033 Bypass: on one edge, wr_en r5=0xBEEF with rd_en and ra_sel=rb_sel=5 -> ra_out=rb_out=0xBEEF after that edge.
REQ-034 Scoreboard: lock r7 -> busy_vec=0x0080; read r7 -> ra_busy=1; write r7=0x0001 -> busy_vec=0x0000; read r7 -> ra_out=0x0001, ra_busy=0.
REQ-035 Same-edge conflict: lock r2 and write r2=0x00AA on one edge -> r2=0x00AA and busy_vec[2]=1.
REQ-036 ZERO_REG=1: write r0=0xFFFF and lock r0, then read r0 -> ra_out=0, ra_busy=0, busy_vec[0]=0.
REQ-037 Reset mid-operation: lock r1 and r4, write r4=0x5555, pulse rst=0 between edges -> all outputs 0 immediately; after release, reading r4 returns 0x0000 and busy_vec=0x0000.
